// File: rtl/pwm_cfg_pkg.sv
// Shared definitions for the PWM configuration path: field encodings,
// value ranges and widths used by the button controller and the generator.
package pwm_cfg_pkg;

  localparam int DUTY_W   = 7;
  localparam int POW_W    = 2;
  localparam int DUTY_MAX = 99;
  localparam int POW_MAX  = 3;

  // Button indices into the per-button vectors of the controller
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_SEL  = 2;
  localparam int BTN_N    = 3;

  typedef enum logic [1:0] {
    FIELD_DUTY = 2'd0,
    FIELD_POW2 = 2'd1,
    FIELD_POW5 = 2'd2
  } edit_field_e;

  // Field rotation DUTY -> POW2 -> POW5 -> DUTY; the unused code 3 falls
  // back to DUTY so a corrupted state register recovers on the next SEL.
  function automatic edit_field_e next_field(input edit_field_e field);
    case (field)
      FIELD_DUTY: return FIELD_POW2;
      FIELD_POW2: return FIELD_POW5;
      default:    return FIELD_DUTY;
    endcase
  endfunction

  // One saturating step up or down inside 0..max_value, never wrapping.
  function automatic int sat_step(input int value, input int max_value, input logic up);
    if (up) begin
      return (value >= max_value) ? value : value + 1;
    end
    return (value <= 0) ? 0 : value - 1;
  endfunction

endpackage

// File: rtl/pwm_button_ctrl_btn.sv
// Per-button front end: two-flop synchroniser, counter-based debouncer and
// a press-event generator with optional hold-to-repeat.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RP_W-1:0] RP_DELAY  = RP_W'(REPEAT_DELAY);
  localparam logic [RP_W-1:0] RP_RATE   = RP_W'(REPEAT_RATE);

  logic            sync1_reg;
  logic            sync2_reg;
  logic [DB_W-1:0] db_cnt_reg;
  logic            level_reg;
  logic            level_d_reg;
  logic [RP_W-1:0] rp_cnt_reg;
  logic            rp_active_reg;
  logic [RP_W-1:0] rp_limit;
  logic            rp_fire;
  logic            rise;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
    end else if (sync2_reg == level_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      db_cnt_reg <= '0;
      level_reg  <= sync2_reg;
    end else begin
      db_cnt_reg <= db_cnt_reg + DB_W'(1);
    end
  end

  // Delayed copy of the debounced level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d_reg <= 1'b0;
    end else begin
      level_d_reg <= level_reg;
    end
  end

  assign rise = level_reg & ~level_d_reg;

  // Hold timer: counts cycles since the last event while the level stays high.
  // The counter is 0 in the initial press cycle, so comparing against the
  // limit gives the first repeat exactly REPEAT_DELAY cycles later; reloading
  // with 1 keeps the following repeats REPEAT_RATE cycles apart.
  assign rp_limit = rp_active_reg ? RP_RATE : RP_DELAY;
  assign rp_fire  = REPEAT_EN && level_reg && (rp_cnt_reg == rp_limit);

  // Repeat timer state, cleared whenever the button is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp_cnt_reg    <= '0;
      rp_active_reg <= 1'b0;
    end else if (!REPEAT_EN || !level_reg) begin
      rp_cnt_reg    <= '0;
      rp_active_reg <= 1'b0;
    end else if (rp_fire) begin
      rp_cnt_reg    <= RP_W'(1);
      rp_active_reg <= 1'b1;
    end else begin
      rp_cnt_reg    <= rp_cnt_reg + RP_W'(1);
    end
  end

  assign press = rise | rp_fire;

endmodule

// File: rtl/pwm_button_ctrl.sv
// Front-panel controller: turns UP/DOWN/SEL buttons into edits of the PWM
// generator configuration (duty_cycle, pow2, pow5) with saturating limits.
module pwm_button_ctrl
  import pwm_cfg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int DUTY_RESET      = 50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_sel,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [POW_W-1:0]  pow2,
  output logic [POW_W-1:0]  pow5,
  output logic [1:0]        edit_field,
  output logic              cfg_changed
);

  // An out-of-range reset value is clamped so the output range always holds
  localparam int DUTY_INIT = (DUTY_RESET > DUTY_MAX) ? DUTY_MAX :
                             (DUTY_RESET < 0)        ? 0 : DUTY_RESET;

  logic [BTN_N-1:0]  btn_raw;
  logic [BTN_N-1:0]  btn_evt;
  logic              up_evt;
  logic              down_evt;
  logic              sel_evt;
  logic              edit_en;

  edit_field_e       field_reg;
  edit_field_e       field_next;
  logic [DUTY_W-1:0] duty_reg;
  logic [DUTY_W-1:0] duty_next;
  logic [POW_W-1:0]  pow2_reg;
  logic [POW_W-1:0]  pow2_next;
  logic [POW_W-1:0]  pow5_reg;
  logic [POW_W-1:0]  pow5_next;
  logic              cfg_changed_reg;
  logic              cfg_changed_next;

  assign btn_raw = {btn_sel, btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < BTN_N; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_EN       (gi != BTN_SEL),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_RATE     (REPEAT_RATE)
      ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw[gi]),
        .press   (btn_evt[gi])
      );
    end
  endgenerate

  assign up_evt   = btn_evt[BTN_UP];
  assign down_evt = btn_evt[BTN_DOWN];
  assign sel_evt  = btn_evt[BTN_SEL];

  // SEL takes priority; UP and DOWN together cancel each other
  assign edit_en = !sel_evt && (up_evt ^ down_evt);

  // Edit-field state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      field_reg <= FIELD_DUTY;
    end else begin
      field_reg <= field_next;
    end
  end

  // Edit-field next state: advance on every SEL event
  always_comb begin
    field_next = field_reg;
    if (sel_evt) begin
      field_next = next_field(field_reg);
    end
  end

  // Saturating update of the selected value and change detection
  always_comb begin
    duty_next        = duty_reg;
    pow2_next        = pow2_reg;
    pow5_next        = pow5_reg;
    cfg_changed_next = 1'b0;
    if (edit_en) begin
      case (field_reg)
        FIELD_DUTY: duty_next = DUTY_W'(sat_step(int'(duty_reg), DUTY_MAX, up_evt));
        FIELD_POW2: pow2_next = POW_W'(sat_step(int'(pow2_reg), POW_MAX, up_evt));
        FIELD_POW5: pow5_next = POW_W'(sat_step(int'(pow5_reg), POW_MAX, up_evt));
        default: ;
      endcase
    end
    cfg_changed_next = (duty_next != duty_reg) || (pow2_next != pow2_reg) ||
                       (pow5_next != pow5_reg);
  end

  // Configuration registers; cfg_changed is registered alongside the values
  // so the pulse lines up with the cycle the new value appears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_reg        <= DUTY_W'(DUTY_INIT);
      pow2_reg        <= '0;
      pow5_reg        <= '0;
      cfg_changed_reg <= 1'b0;
    end else begin
      duty_reg        <= duty_next;
      pow2_reg        <= pow2_next;
      pow5_reg        <= pow5_next;
      cfg_changed_reg <= cfg_changed_next;
    end
  end

  assign duty_cycle  = duty_reg;
  assign pow2        = pow2_reg;
  assign pow5        = pow5_reg;
  assign edit_field  = field_reg;
  assign cfg_changed = cfg_changed_reg;

endmodule

// File: tb/tb_pwm_button_ctrl.sv
// Bench for pwm_button_ctrl: directed scenarios plus random presses, all
// compared every cycle against a window/timestamp based behavioural model.
module tb_pwm_button_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int DR = 50;
  localparam logic [31:0] WMASK = 32'((1 << DB) - 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_sel = 1'b0;
  logic [6:0] duty_cycle;
  logic [1:0] pow2;
  logic [1:0] pow5;
  logic [1:0] edit_field;
  logic       cfg_changed;

  pwm_button_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR),
    .DUTY_RESET      (DR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_sel     (btn_sel),
    .duty_cycle  (duty_cycle),
    .pow2        (pow2),
    .pow5        (pow5),
    .edit_field  (edit_field),
    .cfg_changed (cfg_changed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Raw samples per button (bit0 newest); the debounced view is the window of
  // DB samples seen two clocks late. Events come from the rise timestamp.
  logic [31:0] hist [3];
  bit          m_lvl [3];
  int          m_rise [3];
  bit          m_pend [3];
  int          m_cyc;
  int          m_duty, m_pow2, m_pow5, m_field;
  bit          m_chg;

  function automatic int clamp_step(input int v, input int mx, input bit up);
    if (up) return (v < mx) ? v + 1 : v;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 3; b++) begin
      hist[b]   = '0;
      m_lvl[b]  = 1'b0;
      m_rise[b] = 0;
      m_pend[b] = 1'b0;
    end
    m_cyc   = 0;
    m_duty  = DR;
    m_pow2  = 0;
    m_pow5  = 0;
    m_field = 0;
    m_chg   = 1'b0;
  endtask

  task automatic model_edge();
    int          old_v;
    int          age;
    bit          up, dn;
    logic [2:0]  raw;
    logic [31:0] win;
    up    = m_pend[0];
    dn    = m_pend[1];
    m_chg = 1'b0;
    if (m_pend[2]) begin
      m_field = (m_field + 1) % 3;
    end else if (up != dn) begin
      case (m_field)
        0: begin old_v = m_duty; m_duty = clamp_step(m_duty, 99, up); m_chg = (old_v != m_duty); end
        1: begin old_v = m_pow2; m_pow2 = clamp_step(m_pow2, 3, up);  m_chg = (old_v != m_pow2); end
        default: begin old_v = m_pow5; m_pow5 = clamp_step(m_pow5, 3, up); m_chg = (old_v != m_pow5); end
      endcase
    end
    m_cyc++;
    raw = {btn_sel, btn_down, btn_up};
    for (int b = 0; b < 3; b++) begin
      hist[b] = {hist[b][30:0], raw[b]};
      win = (hist[b] >> 2) & WMASK;
      if (!m_lvl[b] && win == WMASK) begin
        m_lvl[b]  = 1'b1;
        m_rise[b] = m_cyc;
      end else if (m_lvl[b] && win == 32'd0) begin
        m_lvl[b] = 1'b0;
      end
      age = m_cyc - m_rise[b];
      m_pend[b] = m_lvl[b] && ((age == 0) ||
                  ((b != 2) && (age >= RD) && ((age - RD) % RR == 0)));
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  int         pulse_cnt = 0;
  int         dut_chg_cnt = 0;
  bit         prev_ok = 1'b0;
  logic [10:0] prev_vals = '0;

  initial begin
    forever begin
      @(negedge clk);
      chk("duty_vs_model",  duty_cycle,  m_duty);
      chk("pow2_vs_model",  pow2,        m_pow2);
      chk("pow5_vs_model",  pow5,        m_pow5);
      chk("field_vs_model", edit_field,  m_field);
      chk("cfg_vs_model",   cfg_changed, m_chg);
      chk("duty_range",     duty_cycle <= 7'd99, 1);
      chk("field_range",    edit_field != 2'd3, 1);
      if (cfg_changed === 1'b1) pulse_cnt++;
      if (rst_n && prev_ok && ({duty_cycle, pow2, pow5} != prev_vals)) dut_chg_cnt++;
      prev_ok   = rst_n;
      prev_vals = {duty_cycle, pow2, pow5};
    end
  end

  // ---------------- stimulus ----------------
  task automatic press(input logic [2:0] m, input int hold, input int gap);
    @(negedge clk);
    {btn_sel, btn_down, btn_up} = m;
    repeat (hold) @(negedge clk);
    {btn_sel, btn_down, btn_up} = 3'b000;
    repeat (gap) @(negedge clk);
    $display("press sel/dn/up=%b hold=%0d gap=%0d -> duty=%0d pow2=%0d pow5=%0d field=%0d",
             m, hold, gap, duty_cycle, pow2, pow5, edit_field);
  endtask

  int base_p;
  int base_c;
  int exp_p2 [4] = '{1, 2, 3, 3};

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("por_duty", duty_cycle, 50);
    chk("por_pow2", pow2, 0);
    chk("por_pow5", pow5, 0);
    chk("por_field", edit_field, 0);
    chk("por_cfg", cfg_changed, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Bouncing UP: never stable for DB samples
    base_p = pulse_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      btn_up = ~btn_up;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    $display("bounce burst done duty=%0d", duty_cycle);
    chk("bounce_duty", duty_cycle, 50);
    chk("bounce_pulses", pulse_cnt - base_p, 0);

    // Clean press: new value exactly DB+3 clocks after the raw edge
    base_p = pulse_cnt;
    @(negedge clk);
    btn_up = 1'b1;
    repeat (6) @(negedge clk);
    chk("lat_before", duty_cycle, 50);
    @(negedge clk);
    chk("lat_duty", duty_cycle, 51);
    chk("lat_pulse", cfg_changed, 1);
    chk("lat_model", m_duty, 51);
    @(negedge clk);
    chk("lat_pulse_end", cfg_changed, 0);
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    $display("clean press done duty=%0d", duty_cycle);
    chk("lat_pulses", pulse_cnt - base_p, 1);

    // Walk duty up to 97 with single presses
    for (int i = 0; i < 46; i++) press(3'b001, 8, 10);
    chk("walk_duty", duty_cycle, 97);
    chk("walk_model", m_duty, 97);

    // Auto-repeat into saturation at 99
    base_p = pulse_cnt;
    @(negedge clk);
    btn_up = 1'b1;
    repeat (7) @(negedge clk);
    chk("rep_first", duty_cycle, 98);
    chk("rep_first_pulse", cfg_changed, 1);
    repeat (19) @(negedge clk);
    chk("rep_wait", duty_cycle, 98);
    @(negedge clk);
    chk("rep_second", duty_cycle, 99);
    chk("rep_second_pulse", cfg_changed, 1);
    repeat (23) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    $display("up hold done duty=%0d", duty_cycle);
    chk("rep_sat_duty", duty_cycle, 99);
    chk("rep_pulses", pulse_cnt - base_p, 2);

    // Long DOWN hold: 99 changes down to 0, then stays there
    base_p = pulse_cnt;
    @(negedge clk);
    btn_down = 1'b1;
    repeat (600) @(negedge clk);
    btn_down = 1'b0;
    repeat (12) @(negedge clk);
    $display("down hold done duty=%0d", duty_cycle);
    chk("down_floor", duty_cycle, 0);
    chk("down_pulses", pulse_cnt - base_p, 99);

    // Field cycling
    press(3'b100, 8, 10);
    chk("sel_1", edit_field, 1);
    press(3'b100, 8, 10);
    chk("sel_2", edit_field, 2);
    press(3'b100, 8, 10);
    chk("sel_0", edit_field, 0);
    press(3'b100, 8, 10);
    for (int i = 0; i < 4; i++) begin
      press(3'b001, 8, 10);
      chk("pow2_step", pow2, exp_p2[i]);
    end
    chk("pow2_duty_kept", duty_cycle, 0);
    chk("pow2_pow5_kept", pow5, 0);

    // Simultaneous events
    base_p = pulse_cnt;
    press(3'b011, 10, 15);
    chk("updn_pow2", pow2, 3);
    chk("updn_field", edit_field, 1);
    press(3'b101, 10, 15);
    chk("selup_field", edit_field, 2);
    chk("selup_pow5", pow5, 0);
    chk("selup_pow2", pow2, 3);
    chk("simul_pulses", pulse_cnt - base_p, 0);

    // Asynchronous reset mid-run, button held through release
    @(negedge clk);
    #2 rst_n = 1'b0;
    btn_up = 1'b1;
    #1;
    $display("reset asserted mid-run");
    chk("rst_duty", duty_cycle, 50);
    chk("rst_pow2", pow2, 0);
    chk("rst_pow5", pow5, 0);
    chk("rst_field", edit_field, 0);
    chk("rst_cfg", cfg_changed, 0);
    chk("rst_model", m_duty, 50);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("held_before", duty_cycle, 50);
    @(negedge clk);
    chk("held_after", duty_cycle, 51);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);

    // Random press sequence
    base_p = pulse_cnt;
    base_c = dut_chg_cnt;
    for (int i = 0; i < 1000; i++) begin
      press(3'($urandom_range(1, 7)), $urandom_range(1, 30), $urandom_range(1, 12));
    end
    repeat (15) @(negedge clk);
    chk("cfg_count", pulse_cnt - base_p, dut_chg_cnt - base_c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
